// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: operation codes, bus widths and FSM states.
package mem_stage_pkg;

  localparam int unsigned RegBus     = 32;
  localparam int unsigned RegAddrBus = 5;
  localparam int unsigned AluOpBus   = 8;

  localparam logic [RegBus-1:0] ZeroWord = '0;

  localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'hE0;
  localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'hE1;
  localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'hE3;
  localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'hE4;
  localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'hE5;
  localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'hE8;
  localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'hE9;
  localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'hEB;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_WAIT = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

  function automatic logic is_load(input logic [AluOpBus-1:0] op);
    return (op == EXE_LB_OP) || (op == EXE_LH_OP) || (op == EXE_LW_OP) ||
           (op == EXE_LBU_OP) || (op == EXE_LHU_OP);
  endfunction

  function automatic logic is_store(input logic [AluOpBus-1:0] op);
    return (op == EXE_SB_OP) || (op == EXE_SH_OP) || (op == EXE_SW_OP);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering for the MEM stage: big-endian lane enables, store data
// replication and sign/zero extension of load data.
module mem_lane_align
  import mem_stage_pkg::*;
(
  input  logic [AluOpBus-1:0] i_aluop,
  input  logic [1:0]          i_addr,
  input  logic [RegBus-1:0]   i_reg2,
  input  logic [RegBus-1:0]   i_rdata,
  output logic [3:0]          o_sel,
  output logic [RegBus-1:0]   o_wdata,
  output logic [RegBus-1:0]   o_ldata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [3:0]  w_byte_sel;
  logic [3:0]  w_half_sel;

  // Lane 3 (bits 31:24) holds the lowest address.
  always_comb begin
    w_byte = '0;
    case (i_addr)
      2'b00:   w_byte = i_rdata[31:24];
      2'b01:   w_byte = i_rdata[23:16];
      2'b10:   w_byte = i_rdata[15:8];
      default: w_byte = i_rdata[7:0];
    endcase
  end

  assign w_half     = i_addr[1] ? i_rdata[15:0] : i_rdata[31:16];
  assign w_byte_sel = 4'b1000 >> i_addr;
  assign w_half_sel = i_addr[1] ? 4'b0011 : 4'b1100;

  always_comb begin
    o_sel   = '0;
    o_wdata = i_reg2;
    o_ldata = ZeroWord;
    case (i_aluop)
      EXE_LB_OP: begin
        o_sel   = w_byte_sel;
        o_ldata = {{24{w_byte[7]}}, w_byte};
      end
      EXE_LBU_OP: begin
        o_sel   = w_byte_sel;
        o_ldata = {24'b0, w_byte};
      end
      EXE_LH_OP: begin
        o_sel   = w_half_sel;
        o_ldata = {{16{w_half[15]}}, w_half};
      end
      EXE_LHU_OP: begin
        o_sel   = w_half_sel;
        o_ldata = {16'b0, w_half};
      end
      EXE_LW_OP: begin
        o_sel   = '1;
        o_ldata = i_rdata;
      end
      EXE_SB_OP: begin
        o_sel   = w_byte_sel;
        o_wdata = {4{i_reg2[7:0]}};
      end
      EXE_SH_OP: begin
        o_sel   = w_half_sel;
        o_wdata = {2{i_reg2[15:0]}};
      end
      EXE_SW_OP: o_sel = '1;
      default:   ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: passes non-memory ops through and runs one handshaked bus
// transaction per load/store. Optional MEM_ALIGN_CHECK_EN adds excp_misalign.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [RegAddrBus-1:0] mem_wd,
  input  logic                  mem_wreg,
  input  logic [DW-1:0]         mem_wdata,
  input  logic [AluOpBus-1:0]   mem_aluop,
  input  logic [AW-1:0]         mem_addr,
  input  logic [DW-1:0]         mem_reg2,
  output logic [RegAddrBus-1:0] wb_wd,
  output logic                  wb_wreg,
  output logic [DW-1:0]         wb_wdata,
  output logic                  stallreq,
  output logic                  dbus_req,
  output logic                  dbus_we,
  output logic [AW-1:0]         dbus_addr,
  output logic [3:0]            dbus_sel,
  output logic [DW-1:0]         dbus_wdata,
  input  logic [DW-1:0]         dbus_rdata,
`ifdef MEM_ALIGN_CHECK_EN
  output logic                  excp_misalign,
`endif
  input  logic                  dbus_ack
);

  mem_state_e        r_state;
  mem_state_e        w_next;
  logic [DW-1:0]     r_rdata_q;
  logic [3:0]        w_sel;
  logic [DW-1:0]     w_store_wdata;
  logic [DW-1:0]     w_load_data;
  logic              w_is_load;
  logic              w_is_store;
  logic              w_misalign;
  logic              w_bus;
  logic              w_excp;

  assign w_is_load  = is_load(mem_aluop);
  assign w_is_store = is_store(mem_aluop);

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign =
    (((mem_aluop == EXE_LH_OP) || (mem_aluop == EXE_LHU_OP) || (mem_aluop == EXE_SH_OP))
      && mem_addr[0]) ||
    (((mem_aluop == EXE_LW_OP) || (mem_aluop == EXE_SW_OP)) && (mem_addr[1:0] != 2'b00));
  assign excp_misalign = w_excp;
`else
  assign w_misalign = 1'b0;
`endif

  mem_lane_align u_align (
    .i_aluop (mem_aluop),
    .i_addr  (mem_addr[1:0]),
    .i_reg2  (mem_reg2),
    .i_rdata (r_rdata_q),
    .o_sel   (w_sel),
    .o_wdata (w_store_wdata),
    .o_ldata (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= MEM_IDLE;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == MEM_WAIT && dbus_ack) r_rdata_q <= dbus_rdata;
    end
  end

  // Bus fields come straight from EX/MEM, which is held still by stallreq.
  always_comb begin
    w_next     = r_state;
    w_bus      = 1'b0;
    w_excp     = 1'b0;
    wb_wd      = '0;
    wb_wreg    = 1'b0;
    wb_wdata   = ZeroWord;
    stallreq   = 1'b0;
    dbus_req   = 1'b0;
    dbus_we    = 1'b0;
    dbus_addr  = '0;
    dbus_sel   = '0;
    dbus_wdata = '0;
    case (r_state)
      MEM_IDLE: begin
        if ((w_is_load || w_is_store) && w_misalign) begin
          w_excp = 1'b1;
        end else if (w_is_load || w_is_store) begin
          w_bus  = 1'b1;
          w_next = MEM_WAIT;
        end else begin
          wb_wd    = mem_wd;
          wb_wreg  = mem_wreg;
          wb_wdata = mem_wdata;
        end
      end
      MEM_WAIT: begin
        w_bus = 1'b1;
        if (dbus_ack) w_next = MEM_DONE;
      end
      MEM_DONE: begin
        w_next = MEM_IDLE;
        wb_wd  = mem_wd;
        if (w_is_load) begin
          wb_wreg  = mem_wreg;
          wb_wdata = w_load_data;
        end
      end
      default: w_next = MEM_IDLE;
    endcase

    if (w_bus) begin
      dbus_req   = 1'b1;
      stallreq   = 1'b1;
      dbus_we    = w_is_store;
      dbus_addr  = {mem_addr[AW-1:2], 2'b00};
      dbus_sel   = w_sel;
      dbus_wdata = w_store_wdata;
    end

    if (!rst) begin
      w_excp     = 1'b0;
      wb_wd      = '0;
      wb_wreg    = 1'b0;
      wb_wdata   = ZeroWord;
      stallreq   = 1'b0;
      dbus_req   = 1'b0;
      dbus_we    = 1'b0;
      dbus_addr  = '0;
      dbus_sel   = '0;
      dbus_wdata = '0;
    end
  end

endmodule
